msg_schedule_stream: RTL and testbench
======================================

Name: msg_schedule_stream

Overview:
- Sequential SHA-2 message-schedule generator.
- Accepts the 16 words of one message block over a valid/ready input and streams W[0..ROUNDS-1] over a valid/ready output, one word per handshake.
- Sits between the block padder and the compression round datapath.
- Parametrised for SHA-256 (32-bit, 64 rounds) and SHA-512 (64-bit, 80 rounds); uses a 16-entry circular window instead of a 64/80-word array.

Parameters:
WORD_W, 32, word width; legal values 32 (SHA-256) or 64 (SHA-512)
ROUNDS, 64, schedule length; 64 when WORD_W=32, 80 when WORD_W=64; any other pairing is a $fatal at elaboration

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  single-cycle pulse; begins a new block; honoured only in IDLE
in_valid  in  1  in_word is valid
in_ready  out  1  block accepts in_word this cycle
in_word  in  WORD_W  message word W[t], t=0..15, big-endian word order
out_valid  out  1  out_word/out_idx are valid
out_ready  in  1  consumer accepts out_word this cycle
out_word  out  WORD_W  schedule word W[out_idx]
out_idx  out  7  round index t of out_word
busy  out  1  high from the cycle after an accepted start until done
done  out  1  one-cycle pulse after W[ROUNDS-1] is consumed

Behaviour:
- Reset (async assert, sync release): state=IDLE, t=0, window cleared; out_valid=0, out_word=0, out_idx=0, in_ready=0, busy=0, done=0.
- Reset mid-operation aborts the block immediately; no done pulse is generated.
- Output register: a single stage. The stage can load when (!out_valid || out_ready).
  - Once out_valid=1, out_word and out_idx hold until out_ready=1.
  - Full throughput of 1 word/cycle when out_ready is held high.
- States:
  - IDLE: in_ready=0. On start go to LOAD and set t=0.
  - LOAD: in_ready = (!out_valid || out_ready).
    - On in_valid&&in_ready: win[t%16] <= in_word, out_word <= in_word, out_idx <= t, out_valid <= 1, t <= t+1.
    - After t=15 is accepted, go to EXPAND.
    - in_valid while in_ready=0 has no effect.
  - EXPAND: in_ready=0. When the stage can load:
    - W = s1(win[(t-2)%16]) + win[(t-7)%16] + s0(win[(t-15)%16]) + win[t%16], sum mod 2^WORD_W with carries discarded.
    - The win[t%16] read is W[t-16]; win[t%16] <= W, out_word <= W, out_idx <= t, out_valid <= 1, t <= t+1.
    - After t=ROUNDS-1 is issued, go to DRAIN.
  - DRAIN: wait for out_valid&&out_ready on the last word. On that cycle, out_valid falls, done=1 on the next cycle, and state returns to IDLE.
- Latency: out_valid rises the cycle after the in_word accept. The first EXPAND word appears the cycle after W[15] is consumed, or the same edge W[15] is consumed if out_ready is high.
- start while busy is ignored; start coincident with done is ignored.
- Index wrap: window addresses are 4-bit modulo 16; t counts 0..ROUNDS-1 and never wraps inside a block.
- sigma functions:
  - WORD_W=32: s0 = ROTR7^ROTR18^SHR3; s1 = ROTR17^ROTR19^SHR10.
  - WORD_W=64: s0 = ROTR1^ROTR8^SHR7; s1 = ROTR19^ROTR61^SHR6.

Decomposition:
- Shared package sha2_pkg:
  - rotation/shift constants for the s0/s1 functions of both widths;
  - state encoding enum {IDLE, LOAD, EXPAND, DRAIN};
  - ROUNDS lookup function keyed by WORD_W.
- Sub-module sched_sigma: params WORD_W and SEL (0 = s0, 1 = s1); purely combinational; instantiated twice.

Test Plan:
1. WORD_W=32, "abc" block (W0=61626380, W1..W14=0, W15=00000018), out_ready=1 -> W16=61626380, W17=000F0000, out_idx 0..63 contiguous, done pulse exactly once, after idx 63.
2. WORD_W=32, W1=00000001, all others 0 -> W16=02004000 (s0(1)), W0..W15 echoed unchanged.
3. WORD_W=64, ROUNDS=80, W1=1, all others 0 -> W16=8100000000000000, last out_idx=79.
4. Backpressure: out_ready=0 for 5 cycles while out_idx=20 -> out_word/out_idx stable throughout, no index skipped or duplicated, same W sequence as test 1.
5. Input stalls: in_valid toggled 1-0-1 during LOAD; start pulsed while busy -> only valid-cycle words stored, second start ignored, results match test 1.
6. rst_n asserted at out_idx=40 -> all outputs 0 asynchronously, no done pulse; a new start then reproduces test 1 exactly.

Source files
------------

// File: rtl/sha2_pkg.sv
// Shared SHA-2 message-schedule definitions: sigma rotate/shift amounts for
// both word widths, the scheduler state encoding and the rounds-per-width lookup.
package sha2_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    EXPAND = 2'd2,
    DRAIN  = 2'd3
  } sched_state_t;

  localparam int S0_ROT_A_32 = 7;
  localparam int S0_ROT_B_32 = 18;
  localparam int S0_SHR_32   = 3;
  localparam int S1_ROT_A_32 = 17;
  localparam int S1_ROT_B_32 = 19;
  localparam int S1_SHR_32   = 10;

  localparam int S0_ROT_A_64 = 1;
  localparam int S0_ROT_B_64 = 8;
  localparam int S0_SHR_64   = 7;
  localparam int S1_ROT_A_64 = 19;
  localparam int S1_ROT_B_64 = 61;
  localparam int S1_SHR_64   = 6;

  // Returns 0 for an unsupported width so the caller can reject it.
  function automatic int rounds_for(input int word_w);
    if (word_w == 32) return 64;
    if (word_w == 64) return 80;
    return 0;
  endfunction

  function automatic int sigma_rot_a(input int word_w, input int sel);
    if (word_w == 64) return (sel == 0) ? S0_ROT_A_64 : S1_ROT_A_64;
    return (sel == 0) ? S0_ROT_A_32 : S1_ROT_A_32;
  endfunction

  function automatic int sigma_rot_b(input int word_w, input int sel);
    if (word_w == 64) return (sel == 0) ? S0_ROT_B_64 : S1_ROT_B_64;
    return (sel == 0) ? S0_ROT_B_32 : S1_ROT_B_32;
  endfunction

  function automatic int sigma_shr(input int word_w, input int sel);
    if (word_w == 64) return (sel == 0) ? S0_SHR_64 : S1_SHR_64;
    return (sel == 0) ? S0_SHR_32 : S1_SHR_32;
  endfunction

endpackage

// File: rtl/sched_sigma.sv
// Small-sigma function of the SHA-2 schedule (SEL=0 -> s0, SEL=1 -> s1).
// Purely combinational, no latency, no flow control.
module sched_sigma
  import sha2_pkg::*;
#(
  parameter int WORD_W = 32,
  parameter int SEL    = 0
)
(
  input  logic [WORD_W-1:0] i_x,
  output logic [WORD_W-1:0] o_y
);

  localparam int ROT_A = sigma_rot_a(WORD_W, SEL);
  localparam int ROT_B = sigma_rot_b(WORD_W, SEL);
  localparam int SHR_N = sigma_shr(WORD_W, SEL);

  logic [WORD_W-1:0] w_rot_a;
  logic [WORD_W-1:0] w_rot_b;
  logic [WORD_W-1:0] w_shr;

  assign w_rot_a = (i_x >> ROT_A) | (i_x << (WORD_W - ROT_A));
  assign w_rot_b = (i_x >> ROT_B) | (i_x << (WORD_W - ROT_B));
  assign w_shr   = i_x >> SHR_N;
  assign o_y     = w_rot_a ^ w_rot_b ^ w_shr;

endmodule

// File: rtl/msg_schedule_stream.sv
// Streams SHA-2 W[0..ROUNDS-1] from a 16-word block using a 16-entry circular window.
// One output register stage: 1 cycle latency, 1 word/cycle; out_ready low freezes the stage and stalls input/expansion.
module msg_schedule_stream
  import sha2_pkg::*;
#(
  parameter int WORD_W = 32,
  parameter int ROUNDS = 64
)
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] in_word,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WORD_W-1:0] out_word,
  output logic [6:0]        out_idx,
  output logic              busy,
  output logic              done
);

  if ((rounds_for(WORD_W) == 0) || (ROUNDS != rounds_for(WORD_W))) begin : g_bad_cfg
    $fatal(1, "msg_schedule_stream: WORD_W=%0d with ROUNDS=%0d is not a SHA-2 pairing", WORD_W, ROUNDS);
  end

  localparam logic [6:0] LAST_T  = 7'(ROUNDS - 1);
  localparam logic [6:0] LAST_IN = 7'd15;

  sched_state_t      r_state;
  sched_state_t      w_state_nxt;
  logic [6:0]        r_t;
  logic [WORD_W-1:0] r_win [16];
  logic              r_out_vld;
  logic [WORD_W-1:0] r_out_word;
  logic [6:0]        r_out_idx;
  logic              r_done;

  logic              w_can_load;
  logic              w_start_acc;
  logic              w_in_acc;
  logic              w_exp_issue;
  logic              w_drain_fire;
  logic [3:0]        w_idx0;
  logic [3:0]        w_idx2;
  logic [3:0]        w_idx7;
  logic [3:0]        w_idx15;
  logic [WORD_W-1:0] w_s0;
  logic [WORD_W-1:0] w_s1;
  logic [WORD_W-1:0] w_expand;

  assign w_can_load = !r_out_vld || out_ready;

  // Window slot t%16 still holds W[t-16] until it is overwritten with W[t].
  assign w_idx0  = r_t[3:0];
  assign w_idx2  = r_t[3:0] - 4'd2;
  assign w_idx7  = r_t[3:0] - 4'd7;
  assign w_idx15 = r_t[3:0] - 4'd15;

  sched_sigma #(.WORD_W(WORD_W), .SEL(0)) u_sig0 (
    .i_x (r_win[w_idx15]),
    .o_y (w_s0)
  );

  sched_sigma #(.WORD_W(WORD_W), .SEL(1)) u_sig1 (
    .i_x (r_win[w_idx2]),
    .o_y (w_s1)
  );

  assign w_expand = w_s1 + r_win[w_idx7] + w_s0 + r_win[w_idx0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    in_ready     = 1'b0;
    w_start_acc  = 1'b0;
    w_in_acc     = 1'b0;
    w_exp_issue  = 1'b0;
    w_drain_fire = 1'b0;
    case (r_state)
      IDLE: begin
        // A start landing on the done cycle is dropped.
        if (start && !r_done) begin
          w_start_acc = 1'b1;
          w_state_nxt = LOAD;
        end
      end
      LOAD: begin
        in_ready = w_can_load;
        w_in_acc = in_valid && w_can_load;
        if (w_in_acc && (r_t == LAST_IN)) w_state_nxt = EXPAND;
      end
      EXPAND: begin
        w_exp_issue = w_can_load;
        if (w_can_load && (r_t == LAST_T)) w_state_nxt = DRAIN;
      end
      DRAIN: begin
        w_drain_fire = r_out_vld && out_ready;
        if (w_drain_fire) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_t        <= 7'd0;
      r_out_vld  <= 1'b0;
      r_out_word <= '0;
      r_out_idx  <= 7'd0;
      r_done     <= 1'b0;
      for (int i = 0; i < 16; i++) r_win[i] <= '0;
    end else begin
      r_done <= w_drain_fire;
      if (w_start_acc) begin
        r_t <= 7'd0;
      end else if (w_in_acc || w_exp_issue) begin
        r_t <= r_t + 7'd1;
      end
      if (w_in_acc) begin
        r_win[w_idx0] <= in_word;
      end else if (w_exp_issue) begin
        r_win[w_idx0] <= w_expand;
      end
      if (w_in_acc || w_exp_issue) begin
        r_out_vld  <= 1'b1;
        r_out_word <= w_in_acc ? in_word : w_expand;
        r_out_idx  <= r_t;
      end else if (out_ready) begin
        r_out_vld  <= 1'b0;
      end
    end
  end

  assign out_valid = r_out_vld;
  assign out_word  = r_out_word;
  assign out_idx   = r_out_idx;
  assign busy      = (r_state != IDLE);
  assign done      = r_done;

endmodule

// File: tb/tb_msg_schedule_stream.sv
// Scoreboarded bench for msg_schedule_stream: a 32-bit (64 rounds) and a 64-bit
// (80 rounds) instance, randomized stalls and blocks, reference schedule from plain arithmetic.
module tb_msg_schedule_stream;

  typedef struct {
    int          idx;
    logic [63:0] word;
  } exp_t;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        start_a     [2];
  logic        in_valid_a  [2];
  logic        out_ready_a [2];
  logic [63:0] in_word;
  logic        in_ready_a  [2];
  logic        out_valid_a [2];
  logic        busy_a      [2];
  logic        done_a      [2];
  logic [6:0]  out_idx_a   [2];
  logic [31:0] ow32;
  logic [63:0] ow64;
  logic [63:0] out_word_a  [2];

  assign out_word_a[0] = {32'h0, ow32};
  assign out_word_a[1] = ow64;

  msg_schedule_stream #(.WORD_W(32), .ROUNDS(64)) u_dut32 (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start_a[0]),
    .in_valid  (in_valid_a[0]),
    .in_ready  (in_ready_a[0]),
    .in_word   (in_word[31:0]),
    .out_valid (out_valid_a[0]),
    .out_ready (out_ready_a[0]),
    .out_word  (ow32),
    .out_idx   (out_idx_a[0]),
    .busy      (busy_a[0]),
    .done      (done_a[0])
  );

  msg_schedule_stream #(.WORD_W(64), .ROUNDS(80)) u_dut64 (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start_a[1]),
    .in_valid  (in_valid_a[1]),
    .in_ready  (in_ready_a[1]),
    .in_word   (in_word),
    .out_valid (out_valid_a[1]),
    .out_ready (out_ready_a[1]),
    .out_word  (ow64),
    .out_idx   (out_idx_a[1]),
    .busy      (busy_a[1]),
    .done      (done_a[1])
  );

  int          checks = 0;
  int          errors = 0;
  exp_t        q0 [$];
  exp_t        q1 [$];
  logic [63:0] blk [16];
  logic [63:0] obs [2][80];
  int          obs_last [2];
  int          done_cnt [2];
  int          runs_done [2];
  int          bp_mode [2];
  int          stall_cnt [2];
  logic        hold_v [2];
  logic [63:0] hold_w [2];
  logic [6:0]  hold_i [2];
  logic        done_pend [2];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference schedule straight from the SHA-2 definition.
  function automatic logic [63:0] rotr(input logic [63:0] x, input int n, input int w);
    logic [63:0] m;
    m = (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
    return ((x >> n) | (x << (w - n))) & m;
  endfunction

  function automatic logic [63:0] sig0(input logic [63:0] x, input int w);
    if (w == 32) return rotr(x, 7, w) ^ rotr(x, 18, w) ^ (x >> 3);
    return rotr(x, 1, w) ^ rotr(x, 8, w) ^ (x >> 7);
  endfunction

  function automatic logic [63:0] sig1(input logic [63:0] x, input int w);
    if (w == 32) return rotr(x, 17, w) ^ rotr(x, 19, w) ^ (x >> 10);
    return rotr(x, 19, w) ^ rotr(x, 61, w) ^ (x >> 6);
  endfunction

  task automatic push_expected(input int k);
    logic [63:0] wv [80];
    logic [63:0] m;
    int          w;
    int          r;
    exp_t        e;
    w = (k == 1) ? 64 : 32;
    r = (k == 1) ? 80 : 64;
    m = (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
    for (int t = 0; t < r; t++) begin
      if (t < 16) wv[t] = blk[t] & m;
      else wv[t] = (sig1(wv[t-2], w) + wv[t-7] + sig0(wv[t-15], w) + wv[t-16]) & m;
      e.idx  = t;
      e.word = wv[t];
      if (k == 1) q1.push_back(e);
      else q0.push_back(e);
    end
  endtask

  task automatic mon_step(input int k);
    exp_t e;
    int   last;
    last = (k == 1) ? 79 : 63;
    if (!rst_n) begin
      hold_v[k]    = 1'b0;
      done_pend[k] = 1'b0;
      return;
    end
    check($sformatf("done%0d", k), {63'h0, done_a[k]}, {63'h0, done_pend[k]});
    if (done_a[k]) done_cnt[k]++;
    done_pend[k] = 1'b0;
    if (hold_v[k]) begin
      check($sformatf("hold_vld%0d", k), {63'h0, out_valid_a[k]}, 64'h1);
      check($sformatf("hold_word%0d", k), out_word_a[k], hold_w[k]);
      check($sformatf("hold_idx%0d", k), {57'h0, out_idx_a[k]}, {57'h0, hold_i[k]});
    end
    hold_v[k] = 1'b0;
    if (out_valid_a[k]) begin
      if (!out_ready_a[k]) begin
        hold_v[k] = 1'b1;
        hold_w[k] = out_word_a[k];
        hold_i[k] = out_idx_a[k];
      end else if ((k == 1) ? (q1.size() == 0) : (q0.size() == 0)) begin
        checks++;
        errors++;
        $display("FAIL unexpected_word%0d: got idx %0d word %h, expected none", k, out_idx_a[k], out_word_a[k]);
      end else begin
        e = (k == 1) ? q1.pop_front() : q0.pop_front();
        check($sformatf("idx%0d", k), {57'h0, out_idx_a[k]}, 64'(e.idx));
        check($sformatf("word%0d[%0d]", k, e.idx), out_word_a[k], e.word);
        obs[k][out_idx_a[k]] = out_word_a[k];
        obs_last[k] = int'(out_idx_a[k]);
        if (e.idx == last) done_pend[k] = 1'b1;
      end
    end
  endtask

  always @(negedge clk) begin
    mon_step(0);
    mon_step(1);
  end

  initial begin
    out_ready_a[0] = 1'b1;
    out_ready_a[1] = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      for (int k = 0; k < 2; k++) begin
        case (bp_mode[k])
          0: out_ready_a[k] = 1'b1;
          1: out_ready_a[k] = ($urandom_range(0, 3) != 0);
          default: begin
            if (out_valid_a[k] && out_idx_a[k] == 7'd20 && stall_cnt[k] < 5) begin
              out_ready_a[k] = 1'b0;
              stall_cnt[k]++;
            end else begin
              out_ready_a[k] = 1'b1;
            end
          end
        endcase
      end
    end
  end

  task automatic check_idle_outputs(input int k, input string tag);
    check($sformatf("%s_vld%0d", tag, k), {63'h0, out_valid_a[k]}, 64'h0);
    check($sformatf("%s_word%0d", tag, k), out_word_a[k], 64'h0);
    check($sformatf("%s_idx%0d", tag, k), {57'h0, out_idx_a[k]}, 64'h0);
    check($sformatf("%s_rdy%0d", tag, k), {63'h0, in_ready_a[k]}, 64'h0);
    check($sformatf("%s_busy%0d", tag, k), {63'h0, busy_a[k]}, 64'h0);
    check($sformatf("%s_done%0d", tag, k), {63'h0, done_a[k]}, 64'h0);
  endtask

  task automatic run(input int k, input bit stall_in, input bit extra_start, input int rst_at);
    int guard;
    int last;
    last = (k == 1) ? 79 : 63;
    push_expected(k);
    @(posedge clk); #1;
    start_a[k] = 1'b1;
    @(posedge clk); #1;
    start_a[k] = 1'b0;
    check($sformatf("busy_after_start%0d", k), {63'h0, busy_a[k]}, 64'h1);
    for (int i = 0; i < 16; i++) begin
      if (stall_in && (i % 3 == 1)) begin
        in_valid_a[k] = 1'b0;
        in_word = {$urandom, $urandom};
        @(posedge clk); #1;
      end
      in_valid_a[k] = 1'b1;
      in_word = blk[i];
      if (extra_start && i == 5) start_a[k] = 1'b1;
      guard = 0;
      @(negedge clk);
      while (!in_ready_a[k] && guard < 50) begin
        @(negedge clk);
        guard++;
      end
      if (guard >= 50) check("in_ready_timeout", 64'(guard), 64'h0);
      @(posedge clk); #1;
      start_a[k] = 1'b0;
    end
    in_valid_a[k] = 1'b0;
    in_word = {$urandom, $urandom};
    if (extra_start) begin
      start_a[k] = 1'b1;
      @(posedge clk); #1;
      start_a[k] = 1'b0;
    end
    guard = 0;
    if (rst_at >= 0) begin
      @(negedge clk);
      while (!(out_valid_a[k] && int'(out_idx_a[k]) == rst_at) && guard < 2000) begin
        @(negedge clk);
        guard++;
      end
      if (guard >= 2000) check("reset_point_timeout", 64'(guard), 64'h0);
      #2 rst_n = 1'b0;
      #1;
      check_idle_outputs(k, "abort");
      q0.delete();
      q1.delete();
      @(posedge clk); #1;
      rst_n = 1'b1;
      return;
    end
    @(negedge clk);
    while (!(out_valid_a[k] && out_ready_a[k] && int'(out_idx_a[k]) == last) && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 2000) check("last_word_timeout", 64'(guard), 64'h0);
    runs_done[k]++;
    @(posedge clk); #1;
    if (extra_start) begin
      start_a[k] = 1'b1;
      @(posedge clk); #1;
      start_a[k] = 1'b0;
      check($sformatf("start_on_done_ignored%0d", k), {63'h0, busy_a[k]}, 64'h0);
    end
    repeat (2) @(posedge clk);
    #1;
    check($sformatf("queue_empty%0d", k), 64'((k == 1) ? q1.size() : q0.size()), 64'h0);
    check($sformatf("done_count%0d", k), 64'(done_cnt[k]), 64'(runs_done[k]));
  endtask

  task automatic set_abc();
    for (int i = 0; i < 16; i++) blk[i] = 64'h0;
    blk[0]  = 64'h6162_6380;
    blk[15] = 64'h0000_0018;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    in_word = '0;
    for (int k = 0; k < 2; k++) begin
      start_a[k]    = 1'b0;
      in_valid_a[k] = 1'b0;
      bp_mode[k]    = 0;
      stall_cnt[k]  = 0;
      done_cnt[k]   = 0;
      runs_done[k]  = 0;
      obs_last[k]   = -1;
      hold_v[k]     = 1'b0;
      done_pend[k]  = 1'b0;
    end
    #12;
    check_idle_outputs(0, "reset");
    check_idle_outputs(1, "reset");
    rst_n = 1'b1;

    set_abc();
    run(0, 1'b0, 1'b0, -1);
    check("abc_w16", obs[0][16], 64'h6162_6380);
    check("abc_w17", obs[0][17], 64'h000F_0000);
    check("abc_last_idx", 64'(obs_last[0]), 64'd63);

    for (int i = 0; i < 16; i++) blk[i] = 64'h0;
    blk[1] = 64'h1;
    run(0, 1'b0, 1'b0, -1);
    check("w1_w16_32", obs[0][16], 64'h0200_4000);

    run(1, 1'b0, 1'b0, -1);
    check("w1_w16_64", obs[1][16], 64'h8100_0000_0000_0000);
    check("last_idx_64", 64'(obs_last[1]), 64'd79);

    set_abc();
    bp_mode[0] = 2;
    stall_cnt[0] = 0;
    run(0, 1'b0, 1'b0, -1);
    check("stall_cycles", 64'(stall_cnt[0]), 64'd5);

    bp_mode[0] = 1;
    run(0, 1'b1, 1'b1, -1);
    check("stalled_abc_w17", obs[0][17], 64'h000F_0000);

    bp_mode[0] = 0;
    run(0, 1'b0, 1'b0, 40);
    repeat (3) @(posedge clk);
    #1;
    check("post_abort_done_count", 64'(done_cnt[0]), 64'(runs_done[0]));
    run(0, 1'b0, 1'b0, -1);
    check("rerun_abc_w16", obs[0][16], 64'h6162_6380);

    for (int it = 0; it < 4; it++) begin
      for (int k = 0; k < 2; k++) begin
        for (int i = 0; i < 16; i++) blk[i] = (k == 1) ? {$urandom, $urandom} : {32'h0, $urandom};
        bp_mode[k] = 1;
        run(k, 1'b1, 1'b0, -1);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
